replay_buffer_multi: RTL and testbench
======================================

# replay_buffer_multi

Parametrised replay buffer for the data link layer transmit path. It stores up to DEPTH_TLP outgoing packets together with their sequence numbers, and serialises each packet to the link as DATA_W-bit words. It purges stored packets on ACK, replays the unacknowledged ones on NAK or replay timeout, and counts replays with rollover detection. It replaces the fixed 160-bit / 16-bit, single-depth buffer and sits between the packet assembler and the link framer.

## Interface
Parameters:
- DATA_W, 16, output word width.
- WORDS, 10, words per packet; din width is DATA_W*WORDS.
- DEPTH_TLP, 8, packets stored; power of 2, at least 2.
- SEQ_W, 12, sequence number width.
- REPLAY_MAX, 3, replays allowed before rollover.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  load packet din with sequence seq_in; accepted only when ready=1.
- din  in  DATA_W*WORDS  packet; word k = din[k*DATA_W +: DATA_W], word 0 sent first.
- seq_in  in  SEQ_W  sequence number of the packet on din.
- ack_nak  in  2  01=ACK, 10=NAK, 00/11=no event.
- ack_seq  in  SEQ_W  sequence number carried by the ACK/NAK.
- tim_out  in  1  replay timer expiry pulse.
- busy_n  in  1  1 = downstream accepts a word this cycle.
- dout  out  DATA_W  outgoing word.
- dout_valid  out  1  dout is valid.
- ready  out  1  buffer can accept a packet this cycle.
- replay_active  out  1  a replay is in progress.
- rollover  out  1  one-cycle pulse on replay-count rollover.
- count  out  $clog2(DEPTH_TLP+1)  packets stored.
- parity_err  out  1  sticky storage parity error.

## Operation
- Storage: circular buffer of DEPTH_TLP slots; each slot holds WORDS words plus its seq. head = oldest, tail = next free slot.
- States: IDLE, SEND, PURGE, REPLAY.
- ready = (state==IDLE) & (count<DEPTH_TLP) & no pending event (combinational).
- Write: wr_en & ready stores the packet at tail, increments count, then SEND transmits that slot word 0..WORDS-1, then IDLE.
- ACK/NAK/tim_out arriving outside IDLE are latched into one pending register; a later event overwrites an earlier one.
- IDLE priority: pending or current event > wr_en.
- ACK/NAK enter PURGE. PURGE pops the head, one packet per cycle, while count>0 and ((ack_seq - head_seq) mod 2^SEQ_W) < 2^(SEQ_W-1).
- Any pop clears replay_num to 0.
- After PURGE: an ACK returns to IDLE; a NAK starts the replay check.
- tim_out starts the replay check directly, with no purge.
- Replay check:
  - count==0: IDLE, replay_num unchanged.
  - replay_num==REPLAY_MAX: pulse rollover, clear replay_num, no replay, IDLE.
  - otherwise: increment replay_num and enter REPLAY.
- REPLAY sends every stored packet from head to tail-1, each in word order, with replay_active=1; then IDLE. Stored packets are not removed.
- Transmission flow control: a word advances only in cycles with busy_n=1.
- Wrap-around: head and tail pointers wrap modulo DEPTH_TLP; sequence comparison is modular.
- Reset mid-operation discards all stored packets and pending events.

## Timing
- Reset values: dout=0, dout_valid=0, replay_active=0, rollover=0, count=0, parity_err=0, replay_num=0, state IDLE, ready=1.
- wr_en accepted at edge t: count updates at t; word 0 appears on dout with dout_valid=1 after edge t+1 if busy_n=1 in cycle t+1.
- Each cycle with busy_n=1 in SEND/REPLAY registers the next word, valid after the next edge.
- busy_n=0 produces dout_valid=0 the next cycle and holds the word pointer.
- PURGE takes one cycle per popped packet plus one decision cycle.
- rollover is high for exactly one cycle.
- replay_active rises on the edge entering REPLAY and falls on the edge leaving it.

## Configuration
- REPLAY_BUF_PARITY_EN defined:
  - Each stored word carries an even-parity bit written on load and checked on every read.
  - A mismatch sets parity_err, which stays set until rst; data is still sent.
- REPLAY_BUF_PARITY_EN undefined: no parity storage or checking; parity_err is tied to 0.

## Test plan
- Reset, then write seq 5 with din word k = k+1 and busy_n=1 → dout 1..10 on 10 consecutive cycles; count=1; ready=1 afterwards.
- Write seq 0..7 → count=8, ready=0; ACK seq 3 → 4 pop cycles, count=4, head seq=4.
- With seq 4..7 stored, NAK seq 5 → pops 4 and 5; replays 6 then 7 (20 words) with replay_active=1; replay_num=1.
- Four tim_out events with REPLAY_MAX=3 and no ACK between them → three full replays, then rollover pulse and replay_num=0.
- Write seq 4094, 4095, 0, 1 (SEQ_W=12), then ACK seq 0 → count=1, remaining seq 1. Toggle busy_n every cycle during SEND → the 10 words are delivered with gaps, in order, and none dropped.
- ACK arrives during SEND → it is processed immediately after SEND ends. With REPLAY_BUF_PARITY_EN defined and a forced flip of a stored bit → parity_err=1 on the replay read.

Source files
------------

// File: rtl/replay_buffer_multi.sv
// -----------------------------------------------------------------------------
// replay_buffer_multi
//
// Transmit-side replay buffer for the data link layer. Holds up to DEPTH_TLP
// packets (WORDS words of DATA_W bits each, plus a sequence number) in a
// circular store. Each new packet is serialised to the link once. ACKs purge
// acknowledged packets. NAKs and replay-timer expiries resend everything still
// stored. Replays are counted, and exceeding REPLAY_MAX raises a rollover pulse.
//
// Optional feature macro: REPLAY_BUF_PARITY_EN
//   defined   : every stored word keeps an even-parity bit that is checked on
//               every read; a mismatch sets the sticky parity_err.
//   undefined : no parity storage, parity_err tied low.
//
// Handshakes:
//   Packet input: a packet is taken on a rising edge where wr_en=1 and
//   ready=1.
//   Link output: dout is meaningful only in cycles with dout_valid=1. The
//   buffer registers the next word only in cycles where busy_n=1. A cycle with
//   busy_n=0 gives dout_valid=0 in the following cycle, and the word pointer is
//   held.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   wr_en/din/seq_in  packet load (word k = din[k*DATA_W +: DATA_W])
//   ack_nak/ack_seq   01=ACK, 10=NAK, other=none; with acknowledged sequence
//   tim_out        replay timer expiry pulse
//   busy_n         downstream accepts a word this cycle
//   dout/dout_valid   outgoing word stream
//   ready          a packet can be accepted this cycle
//   replay_active  a replay is in progress
//   rollover       one-cycle pulse when the replay count rolls over
//   count          packets currently stored
//   parity_err     sticky storage parity error
// -----------------------------------------------------------------------------
module replay_buffer_multi #(
  parameter int DATA_W     = 16,
  parameter int WORDS      = 10,
  parameter int DEPTH_TLP  = 8,
  parameter int SEQ_W      = 12,
  parameter int REPLAY_MAX = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [DATA_W*WORDS-1:0]           din,
  input  logic [SEQ_W-1:0]                  seq_in,
  input  logic [1:0]                        ack_nak,
  input  logic [SEQ_W-1:0]                  ack_seq,
  input  logic                              tim_out,
  input  logic                              busy_n,
  output logic [DATA_W-1:0]                 dout,
  output logic                              dout_valid,
  output logic                              ready,
  output logic                              replay_active,
  output logic                              rollover,
  output logic [$clog2(DEPTH_TLP+1)-1:0]    count,
  output logic                              parity_err
);

  localparam int PTR_W = $clog2(DEPTH_TLP);
  localparam int CNT_W = $clog2(DEPTH_TLP + 1);
  localparam int WI_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int RN_W  = (REPLAY_MAX > 0) ? $clog2(REPLAY_MAX + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_PURGE, S_REPLAY} state_t;
  typedef enum logic [1:0] {EV_ACK, EV_NAK, EV_TIM} ev_t;

  state_t state, next_state;

  // storage
  logic [DATA_W-1:0] mem     [DEPTH_TLP][WORDS];
  logic [SEQ_W-1:0]  seq_mem [DEPTH_TLP];

  logic [PTR_W-1:0] head, tail, rd_slot;
  logic [WI_W-1:0]  word_idx;
  logic [CNT_W-1:0] rep_left;
  logic [RN_W-1:0]  replay_num;

  // event captured while busy, and the event currently being processed
  logic             pend_valid;
  ev_t              pend_kind;
  logic [SEQ_W-1:0] pend_seq;
  ev_t              ev_kind_r;
  logic [SEQ_W-1:0] ev_seq_r;

  // combinational control
  logic             cur_ev;
  ev_t              cur_kind;
  ev_t              ev_kind_in;
  logic [SEQ_W-1:0] ev_seq_in;
  logic [SEQ_W-1:0] head_diff;
  logic             can_pop;
  logic             tx_fire;
  logic             last_word;
  logic [DATA_W-1:0] rd_word;
  logic accept, take_ev, pop, run_check, start_rep, do_roll;

  always_comb begin
    cur_ev   = (ack_nak == 2'b01) || (ack_nak == 2'b10) || tim_out;
    cur_kind = EV_TIM;
    if (ack_nak == 2'b01)      cur_kind = EV_ACK;
    else if (ack_nak == 2'b10) cur_kind = EV_NAK;
  end

  // A fresh event is newer than anything pending, so it takes precedence.
  assign ev_kind_in = cur_ev ? cur_kind : pend_kind;
  assign ev_seq_in  = cur_ev ? ack_seq  : pend_seq;

  // Head is acknowledged when ack_seq is at or "after" it in modular order.
  assign head_diff = ev_seq_r - seq_mem[head];
  assign can_pop   = (count != '0) && !head_diff[SEQ_W-1];

  assign tx_fire   = ((state == S_SEND) || (state == S_REPLAY)) && busy_n;
  assign last_word = (word_idx == WI_W'(WORDS - 1));
  assign rd_word   = mem[rd_slot][word_idx];

  assign ready = (state == S_IDLE) && (count < CNT_W'(DEPTH_TLP)) &&
                 !pend_valid && !cur_ev;
  assign replay_active = (state == S_REPLAY);

  // next-state / control
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    take_ev    = 1'b0;
    pop        = 1'b0;
    run_check  = 1'b0;
    start_rep  = 1'b0;
    do_roll    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cur_ev || pend_valid) begin
          take_ev = 1'b1;
          if (ev_kind_in == EV_TIM) run_check = 1'b1;
          else                      next_state = S_PURGE;
        end else if (wr_en && ready) begin
          accept     = 1'b1;
          next_state = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_fire && last_word) next_state = S_IDLE;
      end
      S_PURGE: begin
        // one pop per cycle; the first cycle that cannot pop is the decision
        if (can_pop)                  pop = 1'b1;
        else if (ev_kind_r == EV_ACK) next_state = S_IDLE;
        else                          run_check = 1'b1;
      end
      S_REPLAY: begin
        if (tx_fire && last_word && (rep_left == CNT_W'(1))) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    if (run_check) begin
      if (count == '0) begin
        next_state = S_IDLE;
      end else if (replay_num == RN_W'(REPLAY_MAX)) begin
        do_roll    = 1'b1;
        next_state = S_IDLE;
      end else begin
        start_rep  = 1'b1;
        next_state = S_REPLAY;
      end
    end
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      rd_slot    <= '0;
      word_idx   <= '0;
      rep_left   <= '0;
      replay_num <= '0;
      pend_valid <= 1'b0;
      pend_kind  <= EV_ACK;
      pend_seq   <= '0;
      ev_kind_r  <= EV_ACK;
      ev_seq_r   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      rollover   <= 1'b0;
    end else begin
      state      <= next_state;
      rollover   <= do_roll;
      dout_valid <= 1'b0;
      if (accept) begin
        tail     <= tail + 1'b1;
        count    <= count + 1'b1;
        rd_slot  <= tail;
        word_idx <= '0;
      end
      if (take_ev) begin
        ev_kind_r  <= ev_kind_in;
        ev_seq_r   <= ev_seq_in;
        pend_valid <= 1'b0;
      end
      if ((state != S_IDLE) && cur_ev) begin
        pend_valid <= 1'b1;
        pend_kind  <= cur_kind;
        pend_seq   <= ack_seq;
      end
      if (pop) begin
        head       <= head + 1'b1;
        count      <= count - 1'b1;
        replay_num <= '0;
      end
      if (do_roll) replay_num <= '0;
      if (start_rep) begin
        replay_num <= replay_num + 1'b1;
        rd_slot    <= head;
        word_idx   <= '0;
        rep_left   <= count;
      end
      if (tx_fire) begin
        dout       <= rd_word;
        dout_valid <= 1'b1;
        if (last_word) begin
          word_idx <= '0;
          rd_slot  <= rd_slot + 1'b1;
          rep_left <= rep_left - 1'b1;
        end else begin
          word_idx <= word_idx + 1'b1;
        end
      end
    end
  end

  // packet storage, no reset needed: only slots between head and tail are read
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < WORDS; k++) mem[tail][k] <= din[k*DATA_W +: DATA_W];
      seq_mem[tail] <= seq_in;
    end
  end

`ifdef REPLAY_BUF_PARITY_EN
  logic par_mem [DEPTH_TLP][WORDS];

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < WORDS; k++) par_mem[tail][k] <= ^din[k*DATA_W +: DATA_W];
    end
  end

  // sticky; the word is still sent when its parity is wrong
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (tx_fire && ((^rd_word) != par_mem[rd_slot][word_idx])) begin
      parity_err <= 1'b1;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_replay_buffer_multi.sv
// -----------------------------------------------------------------------------
// tb_replay_buffer_multi
//
// Bench for replay_buffer_multi (default parameters, parity feature off).
// Expected link words are pushed into exp_q when a packet is written or a
// replay is expected. A monitor pops and compares every word the DUT presents.
// The reference model keeps the stored packets as plain queues and applies
// ACK / NAK / timeout rules directly to them.
// -----------------------------------------------------------------------------
module tb_replay_buffer_multi;

  localparam int DW    = 16;
  localparam int WD    = 10;
  localparam int DEPTH = 8;
  localparam int SW    = 12;
  localparam int RMAX  = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [DW*WD-1:0]  din;
  logic [SW-1:0]     seq_in;
  logic [1:0]        ack_nak;
  logic [SW-1:0]     ack_seq;
  logic              tim_out;
  logic              busy_n;
  logic [DW-1:0]     dout;
  logic              dout_valid;
  logic              ready;
  logic              replay_active;
  logic              rollover;
  logic [CW-1:0]     count;
  logic              parity_err;

  replay_buffer_multi #(
    .DATA_W(DW), .WORDS(WD), .DEPTH_TLP(DEPTH), .SEQ_W(SW), .REPLAY_MAX(RMAX)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .seq_in(seq_in),
    .ack_nak(ack_nak), .ack_seq(ack_seq), .tim_out(tim_out), .busy_n(busy_n),
    .dout(dout), .dout_valid(dout_valid), .ready(ready),
    .replay_active(replay_active), .rollover(rollover), .count(count),
    .parity_err(parity_err)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0]    exp_q[$];
  logic [SW-1:0]    st_seq[$];
  logic [DW*WD-1:0] st_data[$];
  int m_rn      = 0;
  int exp_roll  = 0;
  int roll_seen = 0;
  int ra_cycles = 0;
  int v_n       = 0;
  int first_v   = 0;
  int last_v    = 0;
  int busy_mode = 0;
  logic prev_roll = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- busy_n driver ----------------
  initial begin
    busy_n = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (busy_mode)
        0:       busy_n = 1'b1;
        1:       busy_n = ~busy_n;
        default: busy_n = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clk);
    if (rst !== 1'b1) begin
      if (replay_active === 1'b1) ra_cycles++;
      if (rollover === 1'b1) begin
        roll_seen++;
        chk("rollover_width", {31'd0, prev_roll}, 32'd0);
      end
      prev_roll = rollover;
      if (dout_valid === 1'b1) begin
        if (v_n == 0) first_v = cyc;
        last_v = cyc;
        v_n++;
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_word: got %0h expected no word (cycle %0d)", dout, cyc);
        end else begin
          chk("dout", {16'd0, dout}, {16'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic void m_push_words(input logic [DW*WD-1:0] d);
    for (int k = 0; k < WD; k++) exp_q.push_back(d[k*DW +: DW]);
  endfunction

  function automatic void m_purge(input logic [SW-1:0] s);
    logic [SW-1:0] diff;
    while (st_seq.size() > 0) begin
      diff = s - st_seq[0];
      if (int'(diff) >= (1 << (SW - 1))) break;
      void'(st_seq.pop_front());
      void'(st_data.pop_front());
      m_rn = 0;
    end
  endfunction

  function automatic void m_replay_check();
    if (st_seq.size() == 0) return;
    if (m_rn == RMAX) begin
      exp_roll++;
      m_rn = 0;
    end else begin
      m_rn++;
      foreach (st_data[i]) m_push_words(st_data[i]);
    end
  endfunction

  function automatic logic [DW*WD-1:0] rand_pkt();
    logic [DW*WD-1:0] p;
    for (int k = 0; k < WD; k++) p[k*DW +: DW] = DW'($urandom);
    return p;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [SW-1:0] s, input logic [DW*WD-1:0] d, output int acc_cyc);
    int n = 0;
    acc_cyc = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL write_ready_timeout: ready=%b expected 1 within 3000 cycles", ready);
    end else begin
      wr_en   = 1'b1;
      din     = d;
      seq_in  = s;
      acc_cyc = cyc;
      st_seq.push_back(s);
      st_data.push_back(d);
      m_push_words(d);
      @(negedge clk);
      wr_en = 1'b0;
    end
  endtask

  // kind: 0=ACK 1=NAK 2=timeout
  task automatic do_event(input int kind, input logic [SW-1:0] s);
    @(negedge clk);
    ack_seq = s;
    case (kind)
      0: begin ack_nak = 2'b01; m_purge(s); end
      1: begin ack_nak = 2'b10; m_purge(s); m_replay_check(); end
      default: begin tim_out = 1'b1; m_replay_check(); end
    endcase
    @(negedge clk);
    ack_nak = 2'b00;
    tim_out = 1'b0;
  endtask

  task automatic drain_and_check();
    int n = 0;
    while (exp_q.size() > 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain_timeout: %0d words still expected, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (12) @(negedge clk);
    chk("count", {28'd0, count}, st_seq.size());
    chk("ready", {31'd0, ready}, (st_seq.size() < DEPTH) ? 32'd1 : 32'd0);
    chk("rollover_total", roll_seen, exp_roll);
  endtask

  task automatic rand_event(input logic [SW-1:0] ns);
    logic [SW-1:0] s;
    if (st_seq.size() > 0)
      s = st_seq[$urandom_range(0, st_seq.size() - 1)] + SW'($urandom_range(0, 2)) - 1'b1;
    else
      s = ns - 1'b1;
    do_event($urandom_range(0, 2), s);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ac;
    logic [DW*WD-1:0] p;
    logic [SW-1:0] ns;

    rst = 1'b1; wr_en = 1'b0; din = '0; seq_in = '0;
    ack_nak = 2'b00; ack_seq = '0; tim_out = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset values
    chk("rst_dout",          {16'd0, dout}, 32'd0);
    chk("rst_dout_valid",    {31'd0, dout_valid}, 32'd0);
    chk("rst_replay_active", {31'd0, replay_active}, 32'd0);
    chk("rst_rollover",      {31'd0, rollover}, 32'd0);
    chk("rst_count",         {28'd0, count}, 32'd0);
    chk("rst_parity_err",    {31'd0, parity_err}, 32'd0);
    chk("rst_ready",         {31'd0, ready}, 32'd1);

    // single packet, word k = k+1, full-rate link
    for (int k = 0; k < WD; k++) p[k*DW +: DW] = DW'(k + 1);
    v_n = 0;
    do_write(12'd5, p, ac);
    drain_and_check();
    chk("first_word_latency", first_v, ac + 2);
    chk("words_back_to_back", last_v - first_v, 32'd9);
    chk("word_count", v_n, 32'd10);
    do_event(0, 12'd5);
    drain_and_check();

    // fill the buffer, then ACK the first four
    for (int i = 0; i < DEPTH; i++) do_write(SW'(i), rand_pkt(), ac);
    drain_and_check();
    do_event(0, 12'd3);
    drain_and_check();

    // NAK 5: purges 4 and 5, replays 6 and 7
    ra_cycles = 0;
    do_event(1, 12'd5);
    drain_and_check();
    chk("nak_replay_cycles", ra_cycles, 32'd20);

    // ACK 6 clears the replay count; then timeouts up to rollover and beyond
    do_event(0, 12'd6);
    drain_and_check();
    for (int i = 0; i < RMAX + 2; i++) begin
      ra_cycles = 0;
      do_event(2, 12'd0);
      drain_and_check();
      chk("tim_replay_cycles", ra_cycles, (i == RMAX) ? 32'd0 : 32'd10);
    end
    do_event(0, 12'd7);
    drain_and_check();

    // sequence wrap-around
    do_write(12'd4094, rand_pkt(), ac);
    do_write(12'd4095, rand_pkt(), ac);
    do_write(12'd0,    rand_pkt(), ac);
    do_write(12'd1,    rand_pkt(), ac);
    drain_and_check();
    do_event(0, 12'd0);
    drain_and_check();
    do_event(1, 12'd0);   // nothing purged; the remaining packet (seq 1) replays
    drain_and_check();
    do_event(0, 12'd1);
    drain_and_check();

    // link stalls every other cycle during SEND
    busy_mode = 1;
    v_n = 0;
    do_write(12'd10, rand_pkt(), ac);
    drain_and_check();
    chk("toggle_word_count", v_n, 32'd10);
    chk("toggle_span", last_v - first_v, 32'd18);
    busy_mode = 0;

    // ACK and NAK arriving during SEND are handled after SEND completes
    do_write(12'd11, rand_pkt(), ac);
    do_event(0, 12'd11);
    drain_and_check();
    do_write(12'd12, rand_pkt(), ac);
    do_write(12'd13, rand_pkt(), ac);
    do_event(1, 12'd11);
    drain_and_check();

    // reset mid-operation drops packets and a pending event
    do_write(12'd14, rand_pkt(), ac);
    do_event(0, 12'd14);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    st_seq.delete();
    st_data.delete();
    exp_q.delete();
    m_rn = 0;
    rst = 1'b0;
    drain_and_check();
    chk("mid_rst_dout_valid", {31'd0, dout_valid}, 32'd0);

    // randomized traffic against the model
    busy_mode = 2;
    ns = SW'($urandom_range(0, 4095));
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 9) < 5 && st_seq.size() < DEPTH) begin
        do_write(ns, rand_pkt(), ac);
        ns++;
        case ($urandom_range(0, 2))
          0:       begin rand_event(ns); drain_and_check(); end
          1:       drain_and_check();
          default: ;
        endcase
      end else begin
        rand_event(ns);
        drain_and_check();
      end
    end
    drain_and_check();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
